// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the runtime-programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } seq_det_state_t;

  localparam int unsigned SEQ_DET_MAX_LEN_DEF = 16;

endpackage

// File: rtl/seq_det_masked_cmp.sv
// Masked pattern compare: only the low len bits of cand and pattern take part.
module seq_det_masked_cmp #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] cand,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               eq
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign eq = (((cand ^ pattern) & mask) == '0);

endmodule

// File: rtl/detect_n_bit_sequence_param.sv
// Runtime-programmable serial bit-pattern detector with optional saturating hit counter
// (enabled by defining SEQ_DET_HIT_CNT_EN).
module detect_n_bit_sequence_param
  import seq_det_pkg::*;
#(
  parameter  int unsigned MAX_LEN = SEQ_DET_MAX_LEN_DEF,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_bit,
  input  logic               bit_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  output logic               armed,
  output logic               detected,
  output logic [CNT_W-1:0]   hit_count
);

  seq_det_state_t state_q, state_d;
  // The oldest shift-register bit never reaches the comparator, so it is not stored.
  logic [MAX_LEN-2:0] shift_q, shift_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               overlap_q, overlap_d;
  logic               detected_q, detected_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] cand;
  logic [LEN_W:0]     fill_inc;
  logic               cmp_eq;
  logic               cfg_legal;
  logic               sample;
  logic               hit;

  assign cand      = {shift_q, new_bit};
  assign fill_inc  = (LEN_W + 1)'(fill_q) + (LEN_W + 1)'(1);
  assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign sample    = bit_valid && !cfg_load;
  assign hit       = sample && (state_q != UNCFG) && (fill_inc >= {1'b0, len_q}) && cmp_eq;

  seq_det_masked_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .cand    (cand),
    .pattern (pattern_q),
    .len     (len_q),
    .eq      (cmp_eq)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    pattern_d  = pattern_q;
    len_d      = len_q;
    fill_d     = fill_q;
    overlap_d  = overlap_q;
    detected_d = 1'b0;
    cfg_err_d  = 1'b0;

    if (cfg_load) begin
      if (cfg_legal) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        fill_d    = '0;
        state_d   = FILL;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (sample) begin
      shift_d = cand[MAX_LEN-2:0];
      if (state_q != UNCFG) begin
        fill_d     = (fill_inc >= {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];
        detected_d = hit;
        if (hit && !overlap_q) begin
          // Non-overlapping mode: the next match must be built from fresh bits.
          fill_d  = '0;
          state_d = FILL;
        end else if (state_q == FILL && fill_d == len_q) begin
          state_d = ARMED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNCFG;
      shift_q    <= '0;
      pattern_q  <= '0;
      len_q      <= '0;
      fill_q     <= '0;
      overlap_q  <= 1'b0;
      detected_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      pattern_q  <= pattern_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      overlap_q  <= overlap_d;
      detected_q <= detected_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign detected = detected_q;
  assign cfg_err  = cfg_err_q;
  assign armed    = (state_q == ARMED);

`ifdef SEQ_DET_HIT_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
    end else if (hit && (hit_cnt_q != '1)) begin
      hit_cnt_q <= hit_cnt_q + CNT_W'(1);
    end
  end

  assign hit_count = hit_cnt_q;
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_detect_n_bit_sequence_param.sv
// Bench for detect_n_bit_sequence_param: directed vector table, hand sequences, random vs model.
module tb_detect_n_bit_sequence_param;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               new_bit = 1'b0;
  logic               bit_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cfg_err;
  logic               armed;
  logic               detected;
  logic [CNT_W-1:0]   hit_count;

  always #5 clk = ~clk;

  detect_n_bit_sequence_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .new_bit     (new_bit),
    .bit_valid   (bit_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_err     (cfg_err),
    .armed       (armed),
    .detected    (detected),
    .hit_count   (hit_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  string tag  = "init";

  // Reference model: full bit history plus a count of bits seen since the last restart.
  bit               m_cfgd;
  int               m_len;
  logic [MAX_LEN-1:0] m_pat;
  bit               m_ovl;
  int               m_fresh;
  logic [MAX_LEN-1:0] m_hist;
  bit               m_det, m_armed, m_err;
  int               m_cnt;
  localparam int    CNT_MAX = (1 << CNT_W) - 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s cyc%0d: got %0h expected %0h", tag, name, cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic ld, input logic [MAX_LEN-1:0] p,
                            input logic [LW-1:0] l, input logic o, input logic v,
                            input logic b);
    bit match;
    if (r) begin
      m_cfgd = 0; m_len = 0; m_pat = '0; m_ovl = 0; m_fresh = 0; m_hist = '0;
      m_det = 0; m_armed = 0; m_err = 0; m_cnt = 0;
      return;
    end
    m_det = 0;
    m_err = 0;
    if (ld) begin
      if (int'(l) >= 1 && int'(l) <= int'(MAX_LEN)) begin
        m_cfgd = 1; m_len = int'(l); m_pat = p; m_ovl = o; m_fresh = 0;
      end else begin
        m_err = 1;
      end
    end else if (v) begin
      m_hist = {m_hist[MAX_LEN-2:0], b};
      if (m_cfgd) begin
        match = 1;
        for (int k = 0; k < m_len; k++) if (m_hist[k] != m_pat[k]) match = 0;
        if (match && (m_fresh + 1 >= m_len)) begin
          m_det = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
          m_fresh = m_ovl ? m_fresh + 1 : 0;
        end else begin
          m_fresh++;
        end
      end
    end
    m_armed = m_cfgd && (m_fresh >= m_len);
  endtask

  task automatic step(input logic r, input logic ld, input logic [MAX_LEN-1:0] p,
                      input logic [LW-1:0] l, input logic o, input logic v, input logic b);
    rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    bit_valid = v; new_bit = b;
    model_step(r, ld, p, l, o, v, b);
    @(posedge clk);
    #1;
    cyc++;
    check("detected", 32'(detected), 32'(m_det));
    check("armed", 32'(armed), 32'(m_armed));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef SEQ_DET_HIT_CNT_EN
    check("hit_count", 32'(hit_count), 32'(m_cnt));
`else
    check("hit_count", 32'(hit_count), 32'd0);
`endif
  endtask

  task automatic bit_in(input logic b);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, b);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input int l, input logic o);
    step(1'b0, 1'b1, p, LW'(l), o, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic               rst;
    logic               load;
    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    logic               ovl;
    logic               valid;
    logic               nbit;
    logic               exp_det;
    logic               exp_armed;
    logic               exp_err;
  } vec_t;

  function automatic vec_t mk(logic r, logic ld, logic [MAX_LEN-1:0] p, int l, logic o,
                              logic v, logic b, logic d, logic a, logic e);
    vec_t t;
    t.rst = r; t.load = ld; t.pat = p; t.len = LW'(l); t.ovl = o;
    t.valid = v; t.nbit = b; t.exp_det = d; t.exp_armed = a; t.exp_err = e;
    return t;
  endfunction

  vec_t tv[$];

  initial begin
    logic [23:0] stream;
    logic [7:0]  s3;
    logic [4:0]  t4;
    int          det_cnt;
    int          idx;
    logic [MAX_LEN-1:0] rp;
    int          rl;
    logic        rv;

    stream = 24'b0011_0101_1001_1001_1010_1000;
    s3     = 8'b1010_1010;

    // Directed table: reset, overlap/non-overlap runs, valid-gap run, illegal loads.
    tv.push_back(mk(1, 0, '0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 16'b110011, 6, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 24; i++)
      tv.push_back(mk(0, 0, '0, 0, 0, 1, stream[23-i], (i == 12 || i == 16), (i >= 5), 0));
    tv.push_back(mk(0, 1, 16'b110011, 6, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 24; i++)
      tv.push_back(mk(0, 0, '0, 0, 0, 1, stream[23-i], (i == 12),
                      ((i >= 5 && i < 12) || i >= 18), 0));
    tv.push_back(mk(0, 1, 16'b1010, 4, 1, 0, 0, 0, 0, 0));
    for (int j = 0; j < 16; j++)
      tv.push_back(mk(0, 0, '0, 0, 0, (j % 2 == 0), s3[7 - j/2],
                      (j == 6 || j == 10 || j == 14), (j >= 6), 0));
    tv.push_back(mk(0, 1, 16'hffff, 0, 0, 0, 0, 0, 1, 1));
    tv.push_back(mk(0, 1, 16'hffff, MAX_LEN + 1, 0, 0, 0, 0, 1, 1));

    tag = "table";
    foreach (tv[n]) begin
      step(tv[n].rst, tv[n].load, tv[n].pat, tv[n].len, tv[n].ovl, tv[n].valid, tv[n].nbit);
      check($sformatf("v%0d_det", n), 32'(detected), 32'(tv[n].exp_det));
      check($sformatf("v%0d_armed", n), 32'(armed), 32'(tv[n].exp_armed));
      check($sformatf("v%0d_err", n), 32'(cfg_err), 32'(tv[n].exp_err));
    end

    // Prior config (1010, len 4) still detects after the rejected loads.
    tag = "t4_prior";
    bit_in(1'b1);
    check("no_det", 32'(detected), 32'd0);
    bit_in(1'b0);
    check("det", 32'(detected), 32'd1);
    bit_in(1'b1);
    bit_in(1'b0);
    check("det2", 32'(detected), 32'd1);
    bit_in(1'b1);

    // Reload mid-match: old history would match but needs 4 fresh bits first.
    tag = "t4_reload";
    load(16'b1010, 4, 1'b1);
    check("armed_clr", 32'(armed), 32'd0);
    t4 = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      bit_in(t4[4-i]);
      check($sformatf("b%0d", i), 32'(detected), 32'(i == 4));
    end

    // len=1 stream of ones: continuous hits, counter saturation.
    tag = "t5_sat";
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    load(16'b1, 1, 1'b1);
    det_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      bit_in(1'b1);
      if (detected) det_cnt++;
    end
    check("det_cnt", 32'(det_cnt), 32'd300);
`ifdef SEQ_DET_HIT_CNT_EN
    check("cnt_sat", 32'(hit_count), 32'd255);
`else
    check("cnt_off", 32'(hit_count), 32'd0);
`endif

    // Reset mid-stream clears everything; later bits ignored without a load.
    tag = "t6_rst";
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    check("det", 32'(detected), 32'd0);
    check("armed", 32'(armed), 32'd0);
    check("cnt", 32'(hit_count), 32'd0);
    det_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bit_in(1'b1);
      if (detected || armed) det_cnt++;
    end
    check("idle", 32'(det_cnt), 32'd0);

    // Random stimulus against the model.
    tag = "rand";
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 19) == 0) begin
        rp = MAX_LEN'($urandom);
        rl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAX_LEN + 2))
                                         : int'($urandom_range(1, 4));
        rv = (rl >= 1 && rl <= int'(MAX_LEN)) ? 1'($urandom_range(0, 1)) : 1'b0;
        step(1'b0, 1'b1, rp, LW'(rl), 1'($urandom_range(0, 1)), rv, 1'($urandom_range(0, 1)));
      end else begin
        step(1'b0, 1'b0, '0, '0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
    end

    idx = n_tests;
    $display("[TB] %0d tests run, %0d failed", idx, n_fail);
    $finish;
  end

endmodule
